fifo_enq_arbiter: RTL

- Shares the enqueue port of one valid/ready `fifo` between NUM_REQ producers.
- Sits directly in front of the FIFO `enq_*` interface.
- Grants ownership round-robin and holds it for a burst of up to BURST_LEN accepted beats.
- A registered grant FSM adds one cycle of arbitration latency; the data path is a combinational mux from the current owner.

---
 rtl/fifo_enq_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_enq_arbiter.sv
// Round-robin burst arbiter sharing one FIFO enqueue port between NUM_REQ producers.
// Define FIFO_ARB_PRIO_EN to make requester 0 a strict high-priority requester.
module fifo_enq_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     enq_valid,
  output logic [WIDTH-1:0]         enq_data,
  input  logic                     enq_ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned LAST_INT  = BURST_LEN - 1;
  localparam logic [7:0]  LAST_BEAT = LAST_INT[7:0];

  state_t            state, state_nxt;
  logic [ID_W-1:0]   owner, owner_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [7:0]        beat_cnt, beat_cnt_nxt;
  logic [ID_W-1:0]   winner, scan;
  logic              any_req;
  logic              owner_valid;
  logic [WIDTH-1:0]  owner_data;
  logic              accept, release_now, active;

  // Explicit compare keeps the wrap correct when NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (v == ID_W'(NUM_REQ - 1)) return '0;
    else                         return v + 1'b1;
  endfunction

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    scan    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FIFO_ARB_PRIO_EN
      if (!any_req && req_valid[scan] && (scan != '0)) begin
`else
      if (!any_req && req_valid[scan]) begin
`endif
        winner  = scan;
        any_req = 1'b1;
      end
      scan = wrap_inc(scan);
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid[0]) begin
      winner  = '0;
      any_req = 1'b1;
    end
`endif
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Outputs are forced to reset values while rst is low so a mid-burst reset accepts nothing.
  assign active      = rst && (state == BUSY);
  assign accept      = active && owner_valid && enq_ready;
  assign release_now = (accept && (beat_cnt == LAST_BEAT)) || !owner_valid;

  always_comb begin
    enq_valid = 1'b0;
    enq_data  = '0;
    req_ready = '0;
    busy      = 1'b0;
    grant_id  = rst ? owner : '0;
    if (active) begin
      enq_valid = owner_valid;
      enq_data  = owner_data;
      busy      = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (owner == ID_W'(i)) && enq_ready;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt    = winner;
          beat_cnt_nxt = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (accept && (beat_cnt != 8'hFF)) beat_cnt_nxt = beat_cnt + 8'd1;
        if (release_now) begin
          state_nxt = IDLE;
`ifdef FIFO_ARB_PRIO_EN
          if (owner != '0) rr_ptr_nxt = wrap_inc(owner);
`else
          rr_ptr_nxt = wrap_inc(owner);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule
